mem_access_ctrl: RTL and testbench

Multi-cycle memory access sequencer between the SLC-3 control unit and the external 16-bit asynchronous SRAM plus memory-mapped I/O. The control unit issues a one-cycle request with a read/write flag. This block drives the SRAM strobes for a fixed number of cycles, captures read data, and returns a one-cycle acknowledge. The control unit no longer needs hard-coded SRAM wait states, and the switch/hex-display I/O is decoded at address 0xFFFF.

---
 rtl/slc3_mem_pkg.sv | 14 +
 rtl/mem_access_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory access sequencer.
package slc3_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RECOVER,
      IO
   } state_t;

   localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
   localparam int          CNT_W           = 4;

endpackage

// File: rtl/mem_access_ctrl.sv
// Multi-cycle SRAM / memory-mapped I/O access sequencer for the SLC-3 control unit.
// Define SLC3_MEM_IO_EN to decode IO_ADDR as the switch / hex-display port.
module mem_access_ctrl
   import slc3_mem_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req,
   input  logic        We,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR_in,
   output logic [15:0] Rd_data,
   output logic        Ack,
   output logic        Busy,
   output logic [19:0] ADDR,
   output logic [15:0] Data_to_SRAM,
   output logic        Data_drive,
   input  logic [15:0] Data_from_SRAM,
   output logic        Mem_CE_N,
   output logic        Mem_UB_N,
   output logic        Mem_LB_N,
   output logic        Mem_OE_N,
   output logic        Mem_WE_N,
   input  logic [15:0] Switches,
   output logic [15:0] HEX_out
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               we_lat;
   logic [15:0]        mar_lat;
   logic [15:0]        mdr_lat;

`ifdef SLC3_MEM_IO_EN
   logic [15:0]        hex_q;
   assign HEX_out = hex_q;
`else
   logic               unused_io;
   assign unused_io = ^{Switches, IO_ADDR};
   assign HEX_out   = '0;
`endif

   assign Busy         = (state != IDLE);
   assign ADDR         = {4'b0, mar_lat};
   assign Data_to_SRAM = mdr_lat;

   // Strobes are registered: they change on the same edge as the state,
   // so the SRAM never sees a combinational glitch on OE_N/WE_N.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         cnt        <= '0;
         we_lat     <= 1'b0;
         mar_lat    <= '0;
         mdr_lat    <= '0;
         Rd_data    <= '0;
         Ack        <= 1'b0;
         Data_drive <= 1'b0;
         Mem_CE_N   <= 1'b1;
         Mem_UB_N   <= 1'b1;
         Mem_LB_N   <= 1'b1;
         Mem_OE_N   <= 1'b1;
         Mem_WE_N   <= 1'b1;
`ifdef SLC3_MEM_IO_EN
         hex_q      <= '0;
`endif
      end else begin
         // NOTE: non-blocking default; any branch below that raises Ack overrides it.
         Ack <= 1'b0;
         case (state)
            IDLE: begin
               if (Req) begin
                  mar_lat <= MAR;
                  mdr_lat <= MDR_in;
                  we_lat  <= We;
`ifdef SLC3_MEM_IO_EN
                  if (MAR == IO_ADDR) begin
                     state <= IO;
                     Ack   <= 1'b1;
                     if (We) hex_q   <= MDR_in;
                     else    Rd_data <= Switches;
                  end else
`endif
                  begin
                     state      <= ACCESS;
                     cnt        <= CNT_W'(WAIT_CYCLES - 1);
                     Mem_CE_N   <= 1'b0;
                     Mem_UB_N   <= 1'b0;
                     Mem_LB_N   <= 1'b0;
                     Mem_OE_N   <= We;
                     Mem_WE_N   <= ~We;
                     Data_drive <= We;
                  end
               end
            end

            ACCESS: begin
               if (cnt == '0) begin
                  state      <= RECOVER;
                  Ack        <= 1'b1;
                  Mem_CE_N   <= 1'b1;
                  Mem_UB_N   <= 1'b1;
                  Mem_LB_N   <= 1'b1;
                  Mem_OE_N   <= 1'b1;
                  Mem_WE_N   <= 1'b1;
                  // Keep driving the bus one more cycle after WE_N rises for hold time.
                  Data_drive <= we_lat;
                  if (!we_lat) Rd_data <= Data_from_SRAM;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            RECOVER: begin
               state      <= IDLE;
               Data_drive <= 1'b0;
            end

`ifdef SLC3_MEM_IO_EN
            IO: begin
               state <= IDLE;
            end
`endif

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (WAIT_CYCLES = 2).
module tb_mem_access_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Req;
   logic        We;
   logic [15:0] MAR;
   logic [15:0] MDR_in;
   logic [15:0] Rd_data;
   logic        Ack;
   logic        Busy;
   logic [19:0] ADDR;
   logic [15:0] Data_to_SRAM;
   logic        Data_drive;
   logic [15:0] Data_from_SRAM;
   logic        Mem_CE_N, Mem_UB_N, Mem_LB_N, Mem_OE_N, Mem_WE_N;
   logic [15:0] Switches;
   logic [15:0] HEX_out;

   int checks   = 0;
   int failures = 0;
   int ack_count = 0;
   int violations = 0;
   int ack_base;

   always #5 Clk = ~Clk;

   mem_access_ctrl #(.WAIT_CYCLES(2), .IO_ADDR(16'hFFFF)) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .MAR(MAR), .MDR_in(MDR_in),
      .Rd_data(Rd_data), .Ack(Ack), .Busy(Busy), .ADDR(ADDR),
      .Data_to_SRAM(Data_to_SRAM), .Data_drive(Data_drive),
      .Data_from_SRAM(Data_from_SRAM),
      .Mem_CE_N(Mem_CE_N), .Mem_UB_N(Mem_UB_N), .Mem_LB_N(Mem_LB_N),
      .Mem_OE_N(Mem_OE_N), .Mem_WE_N(Mem_WE_N),
      .Switches(Switches), .HEX_out(HEX_out)
   );

   // Ack pulses and bus-safety rules are watched on every falling edge.
   always @(negedge Clk) begin
      if (Ack) ack_count++;
      if (!Mem_OE_N && !Mem_WE_N) violations++;
      if (!Mem_OE_N && Data_drive) violations++;
   end

   task automatic check(input string tag, input logic [19:0] observed, input logic [19:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic strobes_idle(input string tag);
      check({tag, "_ce"}, Mem_CE_N, 1'b1);
      check({tag, "_oe"}, Mem_OE_N, 1'b1);
      check({tag, "_we"}, Mem_WE_N, 1'b1);
      check({tag, "_ub"}, Mem_UB_N, 1'b1);
      check({tag, "_lb"}, Mem_LB_N, 1'b1);
   endtask

   initial begin
      Reset = 1'b1; Req = 1'b1; We = 1'b0; MAR = 16'h0010; MDR_in = 16'h0000;
      Data_from_SRAM = 16'h0000; Switches = 16'h0000;

      // Reset held with Req asserted: nothing may start.
      tick(); tick(); tick();
      strobes_idle("rst");
      check("rst_ack", Ack, 1'b0);
      check("rst_busy", Busy, 1'b0);
      check("rst_hex", HEX_out, 16'h0000);
      check("rst_rd", Rd_data, 16'h0000);
      check("rst_drive", Data_drive, 1'b0);
      check("rst_addr", ADDR, 20'h00000);
      Reset = 1'b0; Req = 1'b0;
      tick();
      check("post_rst_busy", Busy, 1'b0);

      // SRAM read of 0x0010 returning 0x1234.
      Req = 1'b1; We = 1'b0; MAR = 16'h0010; Data_from_SRAM = 16'h1234;
      tick();                                   // cycle 1
      Req = 1'b0;
      check("rd_c1_busy", Busy, 1'b1);
      check("rd_c1_oe", Mem_OE_N, 1'b0);
      check("rd_c1_we", Mem_WE_N, 1'b1);
      check("rd_c1_ce", Mem_CE_N, 1'b0);
      check("rd_c1_ack", Ack, 1'b0);
      check("rd_c1_addr", ADDR, 20'h00010);
      check("rd_c1_drive", Data_drive, 1'b0);
      tick();                                   // cycle 2
      check("rd_c2_oe", Mem_OE_N, 1'b0);
      check("rd_c2_ack", Ack, 1'b0);
      check("rd_c2_rd", Rd_data, 16'h0000);
      tick();                                   // cycle 3
      Data_from_SRAM = 16'hDEAD;
      Req = 1'b1;                               // request during Ack must be ignored
      strobes_idle("rd_c3");
      check("rd_c3_ack", Ack, 1'b1);
      check("rd_c3_rd", Rd_data, 16'h1234);
      check("rd_c3_addr", ADDR, 20'h00010);
      tick();                                   // cycle 4
      Req = 1'b0;
      check("rd_c4_ack", Ack, 1'b0);
      check("rd_c4_busy", Busy, 1'b0);
      check("rd_c4_rd", Rd_data, 16'h1234);
      check("rd_acks", ack_count, 1);

      // SRAM write of 0xBEEF to 0x0020, with a stray Req during ACCESS.
      ack_base = ack_count;
      Req = 1'b1; We = 1'b1; MAR = 16'h0020; MDR_in = 16'hBEEF;
      tick();                                   // cycle 1
      MDR_in = 16'h0000; MAR = 16'h0040; We = 1'b0;  // Req stays high: ignored while busy
      check("wr_c1_we", Mem_WE_N, 1'b0);
      check("wr_c1_oe", Mem_OE_N, 1'b1);
      check("wr_c1_drive", Data_drive, 1'b1);
      check("wr_c1_addr", ADDR, 20'h00020);
      check("wr_c1_data", Data_to_SRAM, 16'hBEEF);
      tick();                                   // cycle 2
      Req = 1'b0;
      check("wr_c2_we", Mem_WE_N, 1'b0);
      check("wr_c2_drive", Data_drive, 1'b1);
      check("wr_c2_addr", ADDR, 20'h00020);
      tick();                                   // cycle 3
      strobes_idle("wr_c3");
      check("wr_c3_drive", Data_drive, 1'b1);
      check("wr_c3_ack", Ack, 1'b1);
      check("wr_c3_data", Data_to_SRAM, 16'hBEEF);
      check("wr_c3_rd", Rd_data, 16'h1234);
      tick();                                   // cycle 4
      check("wr_c4_ack", Ack, 1'b0);
      check("wr_c4_drive", Data_drive, 1'b0);
      check("wr_c4_busy", Busy, 1'b0);
      tick(); tick();
      check("wr_idle_busy", Busy, 1'b0);
      check("wr_acks", ack_count - ack_base, 1);

`ifdef SLC3_MEM_IO_EN
      // Memory-mapped I/O write then read.
      ack_base = ack_count;
      Req = 1'b1; We = 1'b1; MAR = 16'hFFFF; MDR_in = 16'h00A5;
      tick();
      Req = 1'b0;
      check("io_wr_hex", HEX_out, 16'h00A5);
      check("io_wr_ack", Ack, 1'b1);
      check("io_wr_busy", Busy, 1'b1);
      check("io_wr_drive", Data_drive, 1'b0);
      strobes_idle("io_wr");
      check("io_wr_rd", Rd_data, 16'h1234);
      tick();
      check("io_wr_ack_end", Ack, 1'b0);
      check("io_wr_idle", Busy, 1'b0);
      Switches = 16'h0F0F; Req = 1'b1; We = 1'b0; MAR = 16'hFFFF;
      tick();
      Req = 1'b0;
      check("io_rd_rd", Rd_data, 16'h0F0F);
      check("io_rd_ack", Ack, 1'b1);
      strobes_idle("io_rd");
      check("io_rd_hex", HEX_out, 16'h00A5);
      tick();
      check("io_rd_ack_end", Ack, 1'b0);
      check("io_acks", ack_count - ack_base, 2);
`else
      // Without the I/O decode, 0xFFFF is an ordinary SRAM write.
      Req = 1'b1; We = 1'b1; MAR = 16'hFFFF; MDR_in = 16'h00A5;
      tick();
      Req = 1'b0;
      check("noio_we", Mem_WE_N, 1'b0);
      check("noio_addr", ADDR, 20'h0FFFF);
      check("noio_ack", Ack, 1'b0);
      check("noio_hex", HEX_out, 16'h0000);
      tick(); tick();
      check("noio_c3_ack", Ack, 1'b1);
      check("noio_c3_hex", HEX_out, 16'h0000);
      tick();
      check("noio_idle", Busy, 1'b0);
`endif

      // Reset in cycle 1 of a write aborts without Ack.
      ack_base = ack_count;
      Req = 1'b1; We = 1'b1; MAR = 16'h0030; MDR_in = 16'h1111;
      tick();
      Req = 1'b0;
      check("abort_c1_we", Mem_WE_N, 1'b0);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      strobes_idle("abort");
      check("abort_drive", Data_drive, 1'b0);
      check("abort_busy", Busy, 1'b0);
      check("abort_ack", Ack, 1'b0);
      check("abort_rd", Rd_data, 16'h0000);
      check("abort_hex", HEX_out, 16'h0000);
      tick(); tick(); tick();
      check("abort_still_idle", Busy, 1'b0);
      check("abort_no_ack", ack_count - ack_base, 0);
      check("bus_rules", violations, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
